// File: rtl/smart_aircon_pkg.sv
// smart_aircon_pkg: shared zone state codes and counter sizing helper
package smart_aircon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOLING = 2'd1,
    HOLDOFF = 2'd2
  } zone_state_t;

  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/smart_aircon_zone_ctrl.sv
// smart_aircon_zone_ctrl: one zone's hot flag, vacancy counter, state machine and protection timer
module smart_aircon_zone_ctrl
  import smart_aircon_pkg::*;
#(
  parameter int TEMP_W        = 8,
  parameter int MIN_ON_TICKS  = 5,
  parameter int MIN_OFF_TICKS = 3,
  parameter int VACANT_TICKS  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              enable,
  input  logic              grant,
  input  logic [TEMP_W-1:0] setpoint,
  input  logic [TEMP_W-1:0] hyst,
  input  logic [TEMP_W-1:0] temp,
  input  logic              person_present,
  output logic              demand,
  output logic              nxt_cool,
  output logic              turn_on,
  output logic [1:0]        zone_state
);
  localparam int CW = cnt_w(MIN_ON_TICKS, MIN_OFF_TICKS, VACANT_TICKS);

  logic              hot;
  logic [CW-1:0]     vac, tmr, tmr_n;
  logic [TEMP_W:0]   hi;
  zone_state_t       st, st_n;

  assign hi         = {1'b0, setpoint} + {1'b0, hyst};
  assign demand     = enable & hot & (vac < CW'(VACANT_TICKS));
  assign nxt_cool   = (st_n == COOLING);
  assign zone_state = st;

  // hysteresis flag: set wins over clear when the band is zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hot <= 1'b0;
    else hot <= ({1'b0, temp} >= hi) ? 1'b1 : (temp <= setpoint) ? 1'b0 : hot;

  // vacancy counter: presence clears it, ticks age it up to saturation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vac <= CW'(VACANT_TICKS);
    else if (person_present) vac <= '0;
    else if (tick && vac < CW'(VACANT_TICKS)) vac <= vac + CW'(1);

  // next state and timer; a global disable drops cooling immediately
  always_comb begin
    st_n  = st;
    tmr_n = tmr;
    case (st)
      IDLE:
        if (tick && demand && grant) begin
          st_n  = COOLING;
          tmr_n = CW'(MIN_ON_TICKS);
        end
      COOLING:
        if (!enable || (tick && tmr == '0 && !demand)) begin
          st_n  = HOLDOFF;
          tmr_n = CW'(MIN_OFF_TICKS);
        end else if (tick && tmr != '0) tmr_n = tmr - CW'(1);
      HOLDOFF:
        if (tick) begin
          st_n  = (tmr == '0) ? IDLE : HOLDOFF;
          tmr_n = (tmr == '0) ? tmr : tmr - CW'(1);
        end
      default: begin
        st_n  = IDLE;
        tmr_n = '0;
      end
    endcase
  end

  // state, timer and relay drive move together
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st      <= IDLE;
      tmr     <= '0;
      turn_on <= 1'b0;
    end else begin
      st      <= st_n;
      tmr     <= tmr_n;
      turn_on <= nxt_cool;
    end

endmodule

// File: rtl/smart_aircon_zones.sv
// smart_aircon_zones: multi-zone cooling controller with one-start-per-tick arbitration
module smart_aircon_zones
  import smart_aircon_pkg::*;
#(
  parameter int N_ZONES       = 4,
  parameter int TEMP_W        = 8,
  parameter int MIN_ON_TICKS  = 5,
  parameter int MIN_OFF_TICKS = 3,
  parameter int VACANT_TICKS  = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic                          enable,
  input  logic [TEMP_W-1:0]             setpoint,
  input  logic [TEMP_W-1:0]             hyst,
  input  logic [N_ZONES*TEMP_W-1:0]     temp,
  input  logic [N_ZONES-1:0]            person_present,
  output logic [N_ZONES-1:0]            turn_on,
  output logic [N_ZONES*2-1:0]          zone_state,
  output logic [$clog2(N_ZONES+1)-1:0]  active_count
);
  localparam int AW = $clog2(N_ZONES + 1);

  logic [N_ZONES-1:0] demand, req, grant, nxt_cool;
  logic [AW-1:0]      cnt;

  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    smart_aircon_zone_ctrl #(
      .TEMP_W       (TEMP_W),
      .MIN_ON_TICKS (MIN_ON_TICKS),
      .MIN_OFF_TICKS(MIN_OFF_TICKS),
      .VACANT_TICKS (VACANT_TICKS)
    ) u_zone (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .enable        (enable),
      .grant         (grant[z]),
      .setpoint      (setpoint),
      .hyst          (hyst),
      .temp          (temp[z*TEMP_W +: TEMP_W]),
      .person_present(person_present[z]),
      .demand        (demand[z]),
      .nxt_cool      (nxt_cool[z]),
      .turn_on       (turn_on[z]),
      .zone_state    (zone_state[z*2 +: 2])
    );
    assign req[z] = demand[z] & (zone_state[z*2 +: 2] == IDLE);
  end

  assign grant = req & (-req);

  // count zones heading into cooling so the count lines up with turn_on
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_ZONES; i++) cnt = cnt + AW'(nxt_cool[i]);
  end

  // registered active zone count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) active_count <= '0;
    else active_count <= cnt;

endmodule
